// File: rtl/vga_fb_axi_slave.sv
// AXI4 slave that holds the VGA framebuffer in on-chip RAM.
// It serves one read or write burst at a time, with round-robin arbitration between AR and AW.
module vga_fb_axi_slave #(
    parameter logic [31:0] FB_BASE  = 32'h8000_0000,
    parameter int          FB_WORDS = 16384,
    parameter int          ID_W     = 4
) (
    input  logic            clock,
    input  logic            resetn,
    output logic            io_slave_awready,
    input  logic            io_slave_awvalid,
    input  logic [31:0]     io_slave_awaddr,
    input  logic [ID_W-1:0] io_slave_awid,
    input  logic [7:0]      io_slave_awlen,
    input  logic [2:0]      io_slave_awsize,
    input  logic [1:0]      io_slave_awburst,
    output logic            io_slave_wready,
    input  logic            io_slave_wvalid,
    input  logic [63:0]     io_slave_wdata,
    input  logic [7:0]      io_slave_wstrb,
    input  logic            io_slave_wlast,
    input  logic            io_slave_bready,
    output logic            io_slave_bvalid,
    output logic [1:0]      io_slave_bresp,
    output logic [ID_W-1:0] io_slave_bid,
    output logic            io_slave_arready,
    input  logic            io_slave_arvalid,
    input  logic [31:0]     io_slave_araddr,
    input  logic [ID_W-1:0] io_slave_arid,
    input  logic [7:0]      io_slave_arlen,
    input  logic [2:0]      io_slave_arsize,
    input  logic [1:0]      io_slave_arburst,
    input  logic            io_slave_rready,
    output logic            io_slave_rvalid,
    output logic [1:0]      io_slave_rresp,
    output logic [63:0]     io_slave_rdata,
    output logic            io_slave_rlast,
    output logic [ID_W-1:0] io_slave_rid
);
    localparam int AW = $clog2(FB_WORDS);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, WR, BRESP} state_t;
    state_t r_state, w_next;

    logic            r_rdy, r_rd_pri;
    logic [31:0]     r_addr;
    logic [7:0]      r_len, r_beat;
    logic [1:0]      r_burst;
    logic [2:0]      r_size;
    logic [ID_W-1:0] r_id;
    logic            r_rvalid, r_rlast, r_oor, r_werr;
    logic [1:0]      r_rresp, r_bresp;
    logic [63:0]     r_mem [FB_WORDS];
    logic [63:0]     r_ram_q;

    logic        w_ar_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;
    logic        w_wr_last, w_beat_err, w_rd_en, w_we;
    logic [31:0] w_rd_addr, w_step;

    function automatic logic [31:0] f_step(input logic [1:0] burst, input logic [2:0] size);
        logic [2:0] sz;
        sz = (size > 3'd3) ? 3'd3 : size;
        return (burst == 2'b00) ? 32'd0 : (32'd1 << sz);
    endfunction

    // Compare in 33 bits so that a window near 2^32 cannot wrap.
    function automatic logic f_oor(input logic [31:0] a);
        logic [32:0] lo, hi;
        lo = {1'b0, FB_BASE};
        hi = lo + (33'(FB_WORDS) << 3);
        return ({1'b0, a} < lo) || ({1'b0, a} >= hi);
    endfunction

    function automatic logic [AW-1:0] f_idx(input logic [31:0] a);
        return AW'((a - FB_BASE) >> 3);
    endfunction

    assign io_slave_arready = r_rdy && (r_state == IDLE) && !(io_slave_awvalid && !r_rd_pri);
    assign io_slave_awready = r_rdy && (r_state == IDLE) && !(io_slave_arvalid && r_rd_pri);
    assign io_slave_wready  = (r_state == WR);
    assign io_slave_bvalid  = (r_state == BRESP);
    assign io_slave_bresp   = r_bresp;
    assign io_slave_bid     = r_id;
    assign io_slave_rvalid  = r_rvalid;
    assign io_slave_rresp   = r_rresp;
    assign io_slave_rlast   = r_rlast;
    assign io_slave_rid     = r_id;
    assign io_slave_rdata   = (r_rvalid && !r_oor) ? r_ram_q : 64'd0;

    assign w_ar_hs    = io_slave_arvalid && io_slave_arready;
    assign w_aw_hs    = io_slave_awvalid && io_slave_awready;
    assign w_w_hs     = io_slave_wvalid && io_slave_wready;
    assign w_r_hs     = r_rvalid && io_slave_rready;
    assign w_b_hs     = io_slave_bvalid && io_slave_bready;
    assign w_step     = f_step(r_burst, r_size);
    assign w_wr_last  = io_slave_wlast || (r_beat == r_len);
    assign w_beat_err = f_oor(r_addr) || (io_slave_wlast != (r_beat == r_len));
    assign w_we       = w_w_hs && !f_oor(r_addr);
    // The RAM read for the next beat is issued on the handshake that retires the current one.
    assign w_rd_en    = w_ar_hs || ((r_state == RD) && w_r_hs && !r_rlast);
    assign w_rd_addr  = (r_state == IDLE) ? io_slave_araddr : r_addr;

    always_ff @(posedge clock) begin
        if (w_we)
            for (int b = 0; b < 8; b++)
                if (io_slave_wstrb[b]) r_mem[f_idx(r_addr)][8*b +: 8] <= io_slave_wdata[8*b +: 8];
        if (w_rd_en) r_ram_q <= r_mem[f_idx(w_rd_addr)];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_ar_hs) w_next = RD;
                     else if (w_aw_hs) w_next = WR;
            RD:      if (w_r_hs && r_rlast) w_next = IDLE;
            WR:      if (w_w_hs && w_wr_last) w_next = BRESP;
            BRESP:   if (w_b_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // In RD, r_addr points at the beat after the one on the bus. In WR, it points at the beat being accepted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rdy    <= 1'b0;
            r_rd_pri <= 1'b1;
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_burst  <= '0;
            r_size   <= '0;
            r_id     <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_oor    <= 1'b0;
            r_werr   <= 1'b0;
            r_rresp  <= OKAY;
            r_bresp  <= OKAY;
        end else begin
            r_rdy <= 1'b1;
            if (w_ar_hs) begin
                r_rd_pri <= 1'b0;
                r_id     <= io_slave_arid;
                r_len    <= io_slave_arlen;
                r_burst  <= io_slave_arburst;
                r_size   <= io_slave_arsize;
                r_addr   <= io_slave_araddr + f_step(io_slave_arburst, io_slave_arsize);
                r_beat   <= '0;
                r_rvalid <= 1'b1;
                r_rlast  <= (io_slave_arlen == 8'd0);
                r_oor    <= f_oor(io_slave_araddr);
                r_rresp  <= f_oor(io_slave_araddr) ? SLVERR : OKAY;
            end else if (w_aw_hs) begin
                r_rd_pri <= 1'b1;
                r_id     <= io_slave_awid;
                r_len    <= io_slave_awlen;
                r_burst  <= io_slave_awburst;
                r_size   <= io_slave_awsize;
                r_addr   <= io_slave_awaddr;
                r_beat   <= '0;
                r_werr   <= 1'b0;
            end
            if ((r_state == RD) && w_r_hs) begin
                if (r_rlast) begin
                    r_rvalid <= 1'b0;
                    r_rlast  <= 1'b0;
                end else begin
                    r_addr  <= r_addr + w_step;
                    r_beat  <= r_beat + 8'd1;
                    r_rlast <= ((r_beat + 8'd1) == r_len);
                    r_oor   <= f_oor(r_addr);
                    r_rresp <= f_oor(r_addr) ? SLVERR : OKAY;
                end
            end
            if (w_w_hs) begin
                r_addr <= r_addr + w_step;
                r_beat <= r_beat + 8'd1;
                r_werr <= r_werr || w_beat_err;
                if (w_wr_last) r_bresp <= (r_werr || w_beat_err) ? SLVERR : OKAY;
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_axi_slave.sv
// Directed bench for vga_fb_axi_slave. Expected R/B responses are queued when a request is
// issued, and a negedge monitor checks them against the DUT outputs.
module tb_vga_fb_axi_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 256;

    logic        clock = 1'b0, resetn = 1'b0;
    logic        awready, awvalid = 0, wready, wvalid = 0, wlast = 0, bready = 1, bvalid;
    logic        arready, arvalid = 0, rready = 1, rvalid, rlast;
    logic [31:0] awaddr = 0, araddr = 0;
    logic [3:0]  awid = 0, arid = 0, bid, rid;
    logic [7:0]  awlen = 0, arlen = 0, wstrb = 0;
    logic [2:0]  awsize = 0, arsize = 0;
    logic [1:0]  awburst = 0, arburst = 0, bresp, rresp;
    logic [63:0] wdata = 0, rdata;

    vga_fb_axi_slave #(.FB_BASE(BASE), .FB_WORDS(WORDS), .ID_W(4)) dut (
        .clock(clock), .resetn(resetn),
        .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
        .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
        .io_slave_awburst(awburst), .io_slave_wready(wready), .io_slave_wvalid(wvalid),
        .io_slave_wdata(wdata), .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
        .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
        .io_slave_bid(bid), .io_slave_arready(arready), .io_slave_arvalid(arvalid),
        .io_slave_araddr(araddr), .io_slave_arid(arid), .io_slave_arlen(arlen),
        .io_slave_arsize(arsize), .io_slave_arburst(arburst), .io_slave_rready(rready),
        .io_slave_rvalid(rvalid), .io_slave_rresp(rresp), .io_slave_rdata(rdata),
        .io_slave_rlast(rlast), .io_slave_rid(rid)
    );

    always #5 clock = ~clock;

    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;
    rexp_t       rq[$];
    bexp_t       bq[$];
    rexp_t       re;
    bexp_t       be;
    logic [63:0] mdl [int];
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [1:0] b, input logic [2:0] s);
        logic [2:0] ss;
        ss = (s > 3'd3) ? 3'd3 : s;
        return (b == 2'b00) ? 32'd0 : (32'd1 << ss);
    endfunction
    function automatic logic oor(input logic [31:0] a);
        return ({1'b0, a} < {1'b0, BASE}) || ({1'b0, a} >= ({1'b0, BASE} + 33'(WORDS * 8)));
    endfunction
    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 3) & 32'(WORDS - 1));
    endfunction
    function automatic logic [63:0] mrd(input int ix);
        return mdl.exists(ix) ? mdl[ix] : 64'd0;
    endfunction

    always @(negedge clock) if (resetn) begin
        if (rvalid) begin
            if (rq.size() == 0) chk("r_unexpected_beat", 1, 0);
            else begin
                re = rq[0];
                chk("rdata", rdata, re.data);
                chk("rresp", 64'(rresp), 64'(re.resp));
                chk("rlast", 64'(rlast), 64'(re.last));
                chk("rid", 64'(rid), 64'(re.id));
                if (rready) void'(rq.pop_front());
            end
        end
        if (bvalid) begin
            if (bq.size() == 0) chk("b_unexpected", 1, 0);
            else begin
                be = bq[0];
                chk("bresp", 64'(bresp), 64'(be.resp));
                chk("bid", 64'(bid), 64'(be.id));
                if (bready) void'(bq.pop_front());
            end
            chk("b_overlaps_r", 64'(rvalid), 0);
        end
    end

    task automatic push_read(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] bu, input logic [2:0] sz, input logic [3:0] id);
        logic [31:0] a;
        rexp_t e;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.resp = oor(a) ? 2'b10 : 2'b00;
            e.data = oor(a) ? 64'd0 : mrd(widx(a));
            e.last = (i == int'(len));
            e.id   = id;
            rq.push_back(e);
            a = a + step(bu, sz);
        end
    endtask

    task automatic ar_req(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] bu, input logic [2:0] sz, input logic [3:0] id);
        logic hs;
        hs = 0;
        araddr = addr; arlen = len; arburst = bu; arsize = sz; arid = id; arvalid = 1;
        for (int t = 0; t < 100 && !hs; t++) begin
            @(negedge clock); hs = arready;
            @(posedge clock); #1;
        end
        arvalid = 0;
        chk("ar_handshake", 64'(hs), 1);
        push_read(addr, len, bu, sz, id);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] bu,
                      input logic [2:0] sz, input logic [3:0] id, input int stall, output int cyc);
        int k;
        ar_req(addr, len, bu, sz, id);
        k = 0; cyc = 0;
        rready = (stall == 0) ? 1'b1 : (k % 3 == 0);
        while (rq.size() > 0 && cyc < 400) begin
            @(posedge clock); #1;
            cyc++; k++;
            rready = (stall == 0) ? 1'b1 : (k % 3 == 0);
        end
        rready = 1;
        chk("read_complete", 64'(rq.size()), 0);
        rq.delete();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] bu,
                      input logic [3:0] id, input logic [63:0] base, input logic [7:0] strb,
                      input int wlast_at);
        logic [31:0] a;
        logic [63:0] cur;
        logic        err, hs;
        bexp_t       e;
        int          nb;
        nb  = (wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
        err = (wlast_at != int'(len));
        a   = addr;
        for (int i = 0; i < nb; i++) begin
            if (oor(a)) err = 1;
            else begin
                cur = mrd(widx(a));
                for (int b = 0; b < 8; b++) if (strb[b]) cur[8*b +: 8] = (base + 64'(i)) >> (8*b);
                mdl[widx(a)] = cur;
            end
            a = a + step(bu, 3'd3);
        end
        awaddr = addr; awlen = len; awburst = bu; awsize = 3'd3; awid = id; awvalid = 1;
        hs = 0;
        for (int t = 0; t < 100 && !hs; t++) begin
            @(negedge clock); hs = awready;
            @(posedge clock); #1;
        end
        awvalid = 0;
        chk("aw_handshake", 64'(hs), 1);
        e.resp = err ? 2'b10 : 2'b00; e.id = id;
        bq.push_back(e);
        for (int i = 0; i < nb; i++) begin
            wvalid = 1; wdata = base + 64'(i); wstrb = strb; wlast = (i == wlast_at);
            hs = 0;
            for (int t = 0; t < 100 && !hs; t++) begin
                @(negedge clock); hs = wready;
                @(posedge clock); #1;
            end
            chk("w_handshake", 64'(hs), 1);
        end
        wvalid = 0; wlast = 0;
        for (int t = 0; t < 100 && bq.size() > 0; t++) begin @(posedge clock); #1; end
        chk("b_complete", 64'(bq.size()), 0);
        bq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [3:0]  ord;
        logic        ar_hs, aw_hs, w_hs, done;
        logic [63:0] cur;
        bexp_t       e;

        #12;
        chk("rst_arready", 64'(arready), 0);
        chk("rst_awready", 64'(awready), 0);
        chk("rst_rvalid", 64'(rvalid), 0);
        chk("rst_bvalid", 64'(bvalid), 0);
        chk("rst_wready", 64'(wready), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp_last_ids", {rresp, bresp, rlast, rid, bid}, 0);
        @(negedge clock); resetn = 1;
        @(posedge clock); #1;
        chk("arready_after_reset", 64'(arready), 1);

        // Preload words 0..7 = index, then an 8-beat streaming read
        wr(BASE, 8'd7, 2'b01, 4'd2, 64'd0, 8'hFF, 7);
        rd(BASE, 8'd7, 2'b01, 3'd3, 4'd5, 0, cyc);
        chk("t1_beat_cycles", 64'(cyc), 8);

        // Strobed write into a zeroed word
        wr(BASE + 8, 8'd0, 2'b01, 4'd1, 64'd0, 8'hFF, 0);
        wr(BASE + 8, 8'd0, 2'b01, 4'd9, 64'h1122334455667788, 8'h0F, 0);
        rd(BASE + 8, 8'd0, 2'b01, 3'd3, 4'd6, 0, cyc);

        // Stalled read: rready 1,0,0,1,...
        rd(BASE, 8'd3, 2'b01, 3'd3, 4'd3, 1, cyc);
        chk("t3_stall_cycles", 64'(cyc), 10);

        // FIXED, narrow INCR, WRAP-as-INCR
        rd(BASE + 16, 8'd3, 2'b00, 3'd3, 4'd4, 0, cyc);
        rd(BASE, 8'd3, 2'b01, 3'd2, 4'd8, 0, cyc);
        wr(BASE + 32, 8'd3, 2'b10, 4'd7, 64'hA0, 8'hFF, 3);
        rd(BASE + 32, 8'd3, 2'b10, 3'd5, 4'd7, 0, cyc);

        // Top of window, and reads/writes outside it
        wr(BASE + 32'(8*WORDS) - 8, 8'd0, 2'b01, 4'd3, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0);
        rd(BASE + 32'(8*WORDS) - 8, 8'd1, 2'b01, 3'd3, 4'd11, 0, cyc);
        rd(BASE - 8, 8'd0, 2'b01, 3'd3, 4'd12, 0, cyc);
        rd(32'hFFFF_FFF8, 8'd1, 2'b01, 3'd3, 4'd13, 0, cyc);
        wr(BASE - 8, 8'd0, 2'b01, 4'd14, 64'h55, 8'hFF, 0);

        // wlast early and late
        wr(BASE + 64, 8'd3, 2'b01, 4'd5, 64'h100, 8'hFF, 1);
        wr(BASE + 96, 8'd1, 2'b01, 4'd6, 64'h200, 8'hFF, 5);
        rd(BASE + 64, 8'd7, 2'b01, 3'd3, 4'd2, 0, cyc);

        // Reset in the middle of a 16-beat read
        ar_req(BASE, 8'd15, 2'b01, 3'd3, 4'd7);
        for (int t = 0; t < 100 && rq.size() > 11; t++) begin @(posedge clock); #1; end
        chk("t6_beats_before_reset", 64'(rq.size()), 11);
        #2 resetn = 0;
        #1 chk("t6_rvalid_async_clear", 64'(rvalid), 0);
        rq.delete(); bq.delete();
        repeat (2) @(posedge clock);
        @(negedge clock); resetn = 1;
        @(posedge clock); #1;
        chk("t6_arready_after_release", 64'(arready), 1);
        rd(BASE, 8'd3, 2'b01, 3'd3, 4'd9, 0, cyc);

        // Contested AR/AW after a fresh reset: expect R, W, R, W
        @(negedge clock); resetn = 0;
        @(negedge clock); resetn = 1;
        @(posedge clock); #1;
        ord = 4'd0;
        for (int r = 0; r < 2; r++) begin
            araddr = BASE + 32'(8 * r); arlen = 8'd1; arburst = 2'b01; arsize = 3'd3; arid = 4'hA;
            awaddr = BASE + 32'(128 + 8 * r); awlen = 8'd0; awburst = 2'b01; awsize = 3'd3; awid = 4'hB;
            wdata = 64'hC0DE_0000 + 64'(r); wstrb = 8'hFF; wlast = 1;
            arvalid = 1; awvalid = 1; wvalid = 1; rready = 1;
            done = 0;
            for (int t = 0; t < 80 && !done; t++) begin
                @(negedge clock);
                ar_hs = arvalid && arready; aw_hs = awvalid && awready; w_hs = wvalid && wready;
                @(posedge clock); #1;
                if (ar_hs) begin
                    ord = {ord[2:0], 1'b0}; arvalid = 0;
                    push_read(araddr, arlen, arburst, arsize, arid);
                end
                if (aw_hs) begin
                    ord = {ord[2:0], 1'b1}; awvalid = 0;
                    cur = wdata; mdl[widx(awaddr)] = cur;
                    e.resp = 2'b00; e.id = awid; bq.push_back(e);
                end
                if (w_hs) begin wvalid = 0; wlast = 0; end
                done = !arvalid && !awvalid && !wvalid && rq.size() == 0 && bq.size() == 0;
            end
            chk("t4_round_complete", 64'(done), 1);
            arvalid = 0; awvalid = 0; wvalid = 0; wlast = 0;
            rq.delete(); bq.delete();
        end
        chk("t4_grant_order", 64'(ord), 64'(4'b0101));
        rd(BASE + 128, 8'd1, 2'b01, 3'd3, 4'd1, 0, cyc);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
